// File: rtl/play_pkg.sv
// Shared constants and types for the playback timer and the time display stage.
package play_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [1:0] SR_SEL_44K1     = 2'b00;
    localparam logic [1:0] SR_SEL_48K      = 2'b01;
    localparam logic [1:0] SR_SEL_32K      = 2'b10;
    localparam logic [1:0] SR_SEL_44K1_ALT = 2'b11;

    localparam int ACC_W = 17;

    localparam logic [ACC_W-1:0] RATE_44K1         = 17'd44100;
    localparam logic [ACC_W-1:0] RATE_48K          = 17'd48000;
    localparam logic [ACC_W-1:0] RATE_32K          = 17'd32000;
    localparam logic [ACC_W-1:0] SAMPLES_PER_FRAME = 17'd1152;

    localparam logic [15:0] MAX_SECONDS = 16'd5999;

    function automatic logic [ACC_W-1:0] rate_of(input logic [1:0] sel);
        case (sel)
            SR_SEL_48K:                   rate_of = RATE_48K;
            SR_SEL_32K:                   rate_of = RATE_32K;
            SR_SEL_44K1, SR_SEL_44K1_ALT: rate_of = RATE_44K1;
            default:                      rate_of = RATE_44K1;
        endcase
    endfunction

endpackage

// File: rtl/play_timer_frame_acc.sv
// Sample accumulator: adds one frame of samples and carries out a second when the rate is reached.
module frame_acc
    import play_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             frame_i,
    input  logic             sat_clr_i,
    input  logic [ACC_W-1:0] rate_i,
    output logic             carry_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    // Frame size is below every rate, so a single subtraction always suffices.
    always_comb begin
        sum     = acc_q + SAMPLES_PER_FRAME;
        carry_o = frame_i && (sum >= rate_i);
        acc_d   = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (frame_i) begin
            if (sat_clr_i) begin
                acc_d = '0;
            end else if (carry_o) begin
                acc_d = sum - rate_i;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/play_timer.sv
// Elapsed-playback timer: counts decoded frames into whole seconds for the mm:ss display.
// Define PLAY_TIMER_SAT_EN to saturate SECONDS at MAX_SEC instead of wrapping to 0.
module play_timer
    import play_pkg::*;
#(
    parameter logic [15:0] MAX_SEC = MAX_SECONDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        track_start_i,
    input  logic        stop_i,
    input  logic        pause_i,
    input  logic        frame_done_i,
    input  logic [1:0]  sr_sel_i,
    output logic [15:0] seconds_o,
    output logic        sec_tick_o,
    output logic        running_o
);

    state_e           state_q, state_d;
    logic [15:0]      seconds_q, seconds_d;
    logic             sec_tick_q, sec_tick_d;
    logic [ACC_W-1:0] rate_q, rate_d;
    logic             frame_cnt;
    logic             acc_clr;
    logic             sat_clr;
    logic             carry;
    logic             at_max;

    assign frame_cnt = frame_done_i && (state_q == RUN) && !stop_i && !track_start_i;
    assign acc_clr   = stop_i || track_start_i;
    assign at_max    = (seconds_q == MAX_SEC);

`ifdef PLAY_TIMER_SAT_EN
    assign sat_clr = frame_cnt && at_max;
`else
    assign sat_clr = 1'b0;
`endif

    frame_acc u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (acc_clr),
        .frame_i   (frame_cnt),
        .sat_clr_i (sat_clr),
        .rate_i    (rate_q),
        .carry_o   (carry)
    );

    always_comb begin
        state_d    = state_q;
        seconds_d  = seconds_q;
        sec_tick_d = 1'b0;
        rate_d     = rate_q;
        if (stop_i) begin
            state_d   = IDLE;
            seconds_d = '0;
        end else if (track_start_i) begin
            seconds_d = '0;
            rate_d    = rate_of(sr_sel_i);
            state_d   = pause_i ? HOLD : RUN;
        end else begin
            case (state_q)
                RUN:     if (pause_i)  state_d = HOLD;
                HOLD:    if (!pause_i) state_d = RUN;
                default: state_d = state_q;
            endcase
            if (carry) begin
`ifdef PLAY_TIMER_SAT_EN
                if (!at_max) begin
                    seconds_d  = seconds_q + 16'd1;
                    sec_tick_d = 1'b1;
                end
`else
                seconds_d  = at_max ? 16'd0 : seconds_q + 16'd1;
                sec_tick_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            seconds_q  <= '0;
            sec_tick_q <= 1'b0;
            rate_q     <= RATE_44K1;
        end else begin
            state_q    <= state_d;
            seconds_q  <= seconds_d;
            sec_tick_q <= sec_tick_d;
            rate_q     <= rate_d;
        end
    end

    assign seconds_o  = seconds_q;
    assign sec_tick_o = sec_tick_q;
    assign running_o  = (state_q == RUN);

endmodule
